mouse_tracker: RTL and testbench
================================

Name: mouse_tracker

Overview:
- Converts the PS/2 mouse byte stream into the absolute cursor position `mouse_x`/`mouse_y` consumed by the graphics/rope path.
- Sits between the PS/2 byte receiver (one-cycle `rx_valid` strobe per byte) and the graphics block.
- Assembles 3-byte movement packets, sign-extends the deltas, accumulates position, and clamps it to the visible screen.
- Also exports button state and a per-packet update strobe.

Parameters:
- H_MAX, 639, largest legal `mouse_x`
- V_MAX, 479, largest legal `mouse_y`
- X_INIT, 320, `mouse_x` after reset
- Y_INIT, 240, `mouse_y` after reset
- TIMEOUT, 1000000, clk cycles allowed between bytes of one packet before resync (counter width = clog2(TIMEOUT+1))

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from PS/2 receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- mouse_x  out  10  cursor x, 0..H_MAX
- mouse_y  out  10  cursor y, 0..V_MAX (0 = top)
- btn_left  out  1  left button, registered per packet
- btn_right  out  1  right button, registered per packet
- pkt_valid  out  1  one-cycle pulse when position/buttons update
- sync_err  out  1  one-cycle pulse on discarded byte or timeout

Behaviour:
- Reset (reset=0, async):
  - state=WAIT_B0; `mouse_x`=X_INIT, `mouse_y`=Y_INIT.
  - `btn_left`, `btn_right`, `pkt_valid`, `sync_err` = 0; byte latches and timeout counter = 0.
- Byte 0 format:
  - bit0 L, bit1 R, bit3 always 1.
  - bit4 X sign, bit5 Y sign.
  - bit6 X overflow, bit7 Y overflow.
- Byte 1 = X delta low 8 bits; byte 2 = Y delta low 8 bits.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
  - WAIT_B0, rx_valid and rx_data[3]=1: latch byte0 → WAIT_B1.
  - WAIT_B0, rx_valid and rx_data[3]=0: discard, pulse `sync_err` next cycle, stay in WAIT_B0.
  - WAIT_B1, rx_valid: latch byte1 → WAIT_B2.
  - WAIT_B2, rx_valid: latch byte2 → UPDATE.
  - UPDATE: always lasts exactly one cycle → WAIT_B0.
  - UPDATE with rx_valid: that byte is processed exactly as in WAIT_B0 (next state WAIT_B1 if bit3=1), never dropped.
- Timeout:
  - Counter clears on every accepted byte and counts in WAIT_B1/WAIT_B2 only; it is held at 0 in WAIT_B0/UPDATE.
  - Counter reaching TIMEOUT with no rx_valid that cycle → WAIT_B0, `sync_err` pulse, partial packet discarded.
  - rx_valid in the same cycle as a timeout: the byte wins (accepted, counter cleared).
- Arithmetic (computed in UPDATE):
  - dx = 11-bit sign extension of {b0[4], b1}; dy likewise from {b0[5], b2}.
  - X overflow bit set → dx forced to 0; Y overflow bit set → dy forced to 0.
  - nx = {0,mouse_x} + dx; ny = {0,mouse_y} − dy (PS/2 +Y is up, screen +y is down).
  - Signed clamp: <0 → 0; >H_MAX (resp. V_MAX) → the max; otherwise the value. No wrap-around.
- Latency:
  - Positions, `btn_left`=b0[0] and `btn_right`=b0[1] load at the clock edge ending the UPDATE cycle.
  - `pkt_valid`=1 for exactly that following cycle.
  - byte2 strobe in cycle N → new outputs and `pkt_valid` visible in cycle N+2.
- `mouse_x`, `mouse_y` and buttons hold their value between packets.
- `pkt_valid` and `sync_err` are never high for more than one cycle per event.
- Reset asserted mid-packet: partial packet lost, outputs return to reset values immediately.

Test Plan:
- Reset, then bytes 0x08, 0x0A, 0x05 → in cycle N+2: `mouse_x`=330, `mouse_y`=235, buttons 0, `pkt_valid` 1 for one cycle.
- From reset: bytes 0x19, 0x9C (dx=−100), 0x00 → `mouse_x`=220, `btn_left`=1. Repeat 4× → `mouse_x` clamps at 0, never wraps to 1023.
- From reset: bytes 0x28, 0x00, 0x80 (dy=−128) sent twice → `mouse_y`=479 (clamped). Byte0 0x48 with byte1 0x7F → `mouse_x` unchanged (overflow).
- Byte 0x00 in WAIT_B0 → `sync_err` one pulse, no state change. Then a valid packet updates normally.
- Send 0x08, 0x05, then idle TIMEOUT cycles → `sync_err` pulse, no `pkt_valid`. The next 3-byte packet is decoded from byte0 correctly.
- Byte2 strobe followed by next byte0 strobe in the UPDATE cycle → both packets applied, two `pkt_valid` pulses. Assert reset after byte1 → `mouse_x`=320, `mouse_y`=240 asynchronously.

Source files
------------

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder: 3-byte packets -> clamped absolute cursor position and buttons.
// Latency: byte2 strobe in cycle N -> mouse_x/mouse_y/buttons/pkt_valid visible in cycle N+2.
// No backpressure: every rx_valid strobe is consumed; bad framing or stalls pulse sync_err.
module mouse_tracker #(
    parameter int H_MAX   = 639,
    parameter int V_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       pkt_valid,
    output logic       sync_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [10:0]   X_MAX_S = 11'(H_MAX);
    localparam logic [10:0]   Y_MAX_S = 11'(V_MAX);
    localparam logic [9:0]    X_RST   = 10'(X_INIT);
    localparam logic [9:0]    Y_RST   = 10'(Y_INIT);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } state_t;

    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic sync_one;
        logic unused_b2;
        logic right;
        logic left;
    } hdr_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    hdr_t            b0;
    logic [7:0]      b1, b2;
    logic            ld_b0, ld_b1, ld_b2;
    logic            bad_byte, tmo, do_update;
    logic [10:0]     dx, dy, nx, ny;
    logic [9:0]      x_clamp, y_clamp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_B0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // UPDATE behaves like WAIT_B0 for incoming bytes so a back-to-back header is never lost.
    always_comb begin
        state_nxt = state;
        ld_b0     = 1'b0;
        ld_b1     = 1'b0;
        ld_b2     = 1'b0;
        bad_byte  = 1'b0;
        tmo       = 1'b0;
        do_update = 1'b0;
        case (state)
            WAIT_B0, UPDATE: begin
                do_update = (state == UPDATE);
                state_nxt = WAIT_B0;
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        ld_b0     = 1'b1;
                        state_nxt = WAIT_B1;
                    end else begin
                        bad_byte  = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_valid) begin
                    ld_b1     = 1'b1;
                    state_nxt = WAIT_B2;
                end else if (cnt == CNT_MAX) begin
                    tmo       = 1'b1;
                    state_nxt = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (rx_valid) begin
                    ld_b2     = 1'b1;
                    state_nxt = UPDATE;
                end else if (cnt == CNT_MAX) begin
                    tmo       = 1'b1;
                    state_nxt = WAIT_B0;
                end
            end
            default: state_nxt = WAIT_B0;
        endcase
    end

    always_comb begin
        cnt_nxt = '0;
        if ((state == WAIT_B1 || state == WAIT_B2) && !rx_valid && !tmo) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_comb begin
        dx = b0.x_ovf ? 11'd0 : {{3{b0.x_sign}}, b1};
        dy = b0.y_ovf ? 11'd0 : {{3{b0.y_sign}}, b2};
        // PS/2 +Y points up while screen rows grow downward.
        nx = {1'b0, mouse_x} + dx;
        ny = {1'b0, mouse_y} - dy;
        x_clamp = nx[9:0];
        if (nx[10]) begin
            x_clamp = 10'd0;
        end else if (nx > X_MAX_S) begin
            x_clamp = X_MAX_S[9:0];
        end
        y_clamp = ny[9:0];
        if (ny[10]) begin
            y_clamp = 10'd0;
        end else if (ny > Y_MAX_S) begin
            y_clamp = Y_MAX_S[9:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b0 <= '0;
            b1 <= '0;
            b2 <= '0;
        end else begin
            if (ld_b0) b0 <= rx_data;
            if (ld_b1) b1 <= rx_data;
            if (ld_b2) b2 <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mouse_x   <= X_RST;
            mouse_y   <= Y_RST;
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= do_update;
            sync_err  <= bad_byte | tmo;
            if (do_update) begin
                mouse_x   <= x_clamp;
                mouse_y   <= y_clamp;
                btn_left  <= b0.left;
                btn_right <= b0.right;
            end
        end
    end

endmodule

// File: tb/tb_mouse_tracker.sv
// Randomized and directed checks of mouse_tracker against a packet-level arithmetic model.
module tb_mouse_tracker;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] mouse_x, mouse_y;
    logic       btn_left, btn_right, pkt_valid, sync_err;

    int n_cmp = 0;
    int n_err = 0;
    int mx, my;
    logic ml, mr;

    mouse_tracker #(
        .H_MAX(639), .V_MAX(479), .X_INIT(320), .Y_INIT(240), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .btn_left(btn_left),
        .btn_right(btn_right), .pkt_valid(pkt_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (b0[6]) dx = 0;
        if (b0[7]) dy = 0;
        mx = clampi(mx + dx, 639);
        my = clampi(my - dy, 479);
        ml = b0[0];
        mr = b0[1];
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Returns in the cycle where the packet's outputs should be visible.
    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int gap, output logic early_pv);
        send_byte(b0); idle(gap);
        send_byte(b1); idle(gap);
        send_byte(b2);
        early_pv = pkt_valid;
        @(posedge clk); #1;
        model_pkt(b0, b1, b2);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        mx = 320; my = 240; ml = 1'b0; mr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle(3);
        n_cmp++; if (mouse_x !== 10'd320) begin n_err++; $display("FAIL reset_x: got %0d expected 320", mouse_x); end
        n_cmp++; if (mouse_y !== 10'd240) begin n_err++; $display("FAIL reset_y: got %0d expected 240", mouse_y); end
        n_cmp++; if ({btn_left, btn_right} !== 2'b00) begin n_err++; $display("FAIL reset_btn: got %b%b expected 00", btn_left, btn_right); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL reset_pkt_valid: got %b expected 0", pkt_valid); end
        n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        reset = 1'b1;
        mx = 320; my = 240; ml = 1'b0; mr = 1'b0;
    endtask

    task automatic test_basic();
        logic early;
        do_reset();
        send_packet(8'h08, 8'h0A, 8'h05, 0, early);
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL basic_early_pv: got %b expected 0", early); end
        n_cmp++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL basic_pv: got %b expected 1", pkt_valid); end
        n_cmp++; if (mouse_x !== 10'd330) begin n_err++; $display("FAIL basic_x: got %0d expected 330", mouse_x); end
        n_cmp++; if (mouse_y !== 10'd235) begin n_err++; $display("FAIL basic_y: got %0d expected 235", mouse_y); end
        n_cmp++; if ({btn_left, btn_right} !== 2'b00) begin n_err++; $display("FAIL basic_btn: got %b%b expected 00", btn_left, btn_right); end
        idle(1);
        n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL basic_pv_len: got %b expected 0", pkt_valid); end
        n_cmp++; if (mouse_x !== 10'd330) begin n_err++; $display("FAIL basic_x_hold: got %0d expected 330", mouse_x); end
    endtask

    task automatic test_clamp_x();
        logic early;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_packet(8'h19, 8'h9C, 8'h00, 1, early);
            n_cmp++; if (mouse_x !== mx[9:0]) begin n_err++; $display("FAIL clampx_step%0d: got %0d expected %0d", i, mouse_x, mx); end
            n_cmp++; if (btn_left !== 1'b1) begin n_err++; $display("FAIL clampx_btn_left%0d: got %b expected 1", i, btn_left); end
            if (i == 0) begin
                n_cmp++; if (mouse_x !== 10'd220) begin n_err++; $display("FAIL clampx_first: got %0d expected 220", mouse_x); end
            end
        end
        n_cmp++; if (mouse_x !== 10'd0) begin n_err++; $display("FAIL clampx_floor: got %0d expected 0", mouse_x); end
    endtask

    task automatic test_clamp_y();
        logic early;
        do_reset();
        repeat (2) send_packet(8'h28, 8'h00, 8'h80, 0, early);
        n_cmp++; if (mouse_y !== 10'd479) begin n_err++; $display("FAIL clampy_ceiling: got %0d expected 479", mouse_y); end
        send_packet(8'h48, 8'h7F, 8'h00, 0, early);
        n_cmp++; if (mouse_x !== 10'd320) begin n_err++; $display("FAIL xovf_x: got %0d expected 320", mouse_x); end
        n_cmp++; if (mouse_y !== my[9:0]) begin n_err++; $display("FAIL xovf_y: got %0d expected %0d", mouse_y, my); end
    endtask

    task automatic test_sync();
        logic early;
        idle(2);
        send_byte(8'h00);
        n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_pulse: got %b expected 1", sync_err); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL sync_no_pkt: got %b expected 0", pkt_valid); end
        idle(1);
        n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync_pulse_len: got %b expected 0", sync_err); end
        n_cmp++; if (mouse_x !== mx[9:0]) begin n_err++; $display("FAIL sync_x_hold: got %0d expected %0d", mouse_x, mx); end
        send_packet(8'h0A, 8'h05, 8'hFB, 0, early);
        n_cmp++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL sync_then_pv: got %b expected 1", pkt_valid); end
        n_cmp++; if ({mouse_x, mouse_y} !== {mx[9:0], my[9:0]}) begin n_err++; $display("FAIL sync_then_pos: got %0d,%0d expected %0d,%0d", mouse_x, mouse_y, mx, my); end
        n_cmp++; if (btn_right !== mr) begin n_err++; $display("FAIL sync_then_btn_right: got %b expected %b", btn_right, mr); end
    endtask

    task automatic test_timeout();
        logic early;
        int se_cnt, pv_cnt, first;
        idle(2);
        send_byte(8'h08);
        send_byte(8'h05);
        se_cnt = 0; pv_cnt = 0; first = -1;
        for (int i = 0; i < TMO + 6; i++) begin
            idle(1);
            if (sync_err === 1'b1) begin
                se_cnt++;
                if (first < 0) first = i;
            end
            if (pkt_valid === 1'b1) pv_cnt++;
        end
        n_cmp++; if (se_cnt != 1) begin n_err++; $display("FAIL tmo_sync_count: got %0d expected 1", se_cnt); end
        n_cmp++; if (first < TMO - 1 || first > TMO + 1) begin n_err++; $display("FAIL tmo_sync_time: got %0d expected %0d", first, TMO); end
        n_cmp++; if (pv_cnt != 0) begin n_err++; $display("FAIL tmo_no_pkt: got %0d expected 0", pv_cnt); end
        send_packet(8'h08, 8'h0A, 8'h05, 0, early);
        n_cmp++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL tmo_resync_pv: got %b expected 1", pkt_valid); end
        n_cmp++; if ({mouse_x, mouse_y} !== {mx[9:0], my[9:0]}) begin n_err++; $display("FAIL tmo_resync_pos: got %0d,%0d expected %0d,%0d", mouse_x, mouse_y, mx, my); end
        // A byte arriving on the boundary cycle must still be taken.
        send_packet(8'h08, 8'h03, 8'h02, TMO, early);
        n_cmp++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL tmo_edge_pv: got %b expected 1", pkt_valid); end
        n_cmp++; if ({mouse_x, mouse_y} !== {mx[9:0], my[9:0]}) begin n_err++; $display("FAIL tmo_edge_pos: got %0d,%0d expected %0d,%0d", mouse_x, mouse_y, mx, my); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        int pulses;
        bytes = '{8'h08, 8'h10, 8'h20, 8'h09, 8'hF0, 8'h03};
        idle(2);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            rx_data = bytes[i]; rx_valid = 1'b1;
            @(posedge clk); #1;
            if (pkt_valid === 1'b1) pulses++;
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (pkt_valid === 1'b1) pulses++;
        end
        model_pkt(bytes[0], bytes[1], bytes[2]);
        model_pkt(bytes[3], bytes[4], bytes[5]);
        n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        n_cmp++; if ({mouse_x, mouse_y} !== {mx[9:0], my[9:0]}) begin n_err++; $display("FAIL b2b_pos: got %0d,%0d expected %0d,%0d", mouse_x, mouse_y, mx, my); end
        n_cmp++; if (btn_left !== 1'b1) begin n_err++; $display("FAIL b2b_btn_left: got %b expected 1", btn_left); end
    endtask

    task automatic test_random();
        logic early;
        logic [7:0] b0, b1, b2, junk;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if ($urandom_range(0, 4) == 0) begin
                junk = 8'($urandom);
                junk[3] = 1'b0;
                send_byte(junk);
                n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL rnd_junk%0d: got %b expected 1", i, sync_err); end
            end
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
            b0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
            send_packet(b0, b1, b2, $urandom_range(0, 3), early);
            n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL rnd_early%0d: got %b expected 0", i, early); end
            n_cmp++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL rnd_pv%0d: got %b expected 1", i, pkt_valid); end
            n_cmp++; if ({mouse_x, mouse_y} !== {mx[9:0], my[9:0]}) begin n_err++; $display("FAIL rnd_pos%0d: got %0d,%0d expected %0d,%0d", i, mouse_x, mouse_y, mx, my); end
            n_cmp++; if ({btn_left, btn_right} !== {ml, mr}) begin n_err++; $display("FAIL rnd_btn%0d: got %b%b expected %b%b", i, btn_left, btn_right, ml, mr); end
        end
    endtask

    task automatic test_reset_mid();
        logic early;
        idle(2);
        send_packet(8'h09, 8'h20, 8'h10, 0, early);
        send_byte(8'h08);
        send_byte(8'h0A);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({mouse_x, mouse_y} !== {10'd320, 10'd240}) begin n_err++; $display("FAIL rstmid_pos: got %0d,%0d expected 320,240", mouse_x, mouse_y); end
        n_cmp++; if (btn_left !== 1'b0) begin n_err++; $display("FAIL rstmid_btn: got %b expected 0", btn_left); end
        @(posedge clk); #1;
        reset = 1'b1;
        mx = 320; my = 240; ml = 1'b0; mr = 1'b0;
        send_packet(8'h08, 8'h0A, 8'h05, 0, early);
        n_cmp++; if ({mouse_x, mouse_y} !== {10'd330, 10'd235}) begin n_err++; $display("FAIL rstmid_fresh: got %0d,%0d expected 330,235", mouse_x, mouse_y); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_x();
        test_clamp_y();
        test_sync();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
